// File: rtl/posit_field_extract.sv
// posit_field_extract: two-stage registered decode stage after seed_lookup.
// Stage 1 captures sign, zero/NaR flags, exponent, fraction and the regime
// value k. Stage 2 forms the combined scale k*2^ES + e and the hidden-bit
// mantissa. Optional macro POSIT_FIELD_STATS_EN adds handshake counters
// (stat_count, stat_nar) with a synchronous clear input (stat_clr).
//
// Handshake: a word transfers on a port in any cycle where valid and ready
// are both high at the rising clock edge. A producer holds valid and data
// stable until the transfer; ready may depend combinationally on the
// downstream ready (in_ready follows out_ready with no bubble).
module posit_field_extract #(
    parameter int BITS    = 32,
    parameter int ES      = 2,
    parameter int SCALE_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BITS-1:0]          in_raw,
    input  logic [BITS-1:0]          in_seed,
    input  logic [BITS-1:0]          in_shifted,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sign,
    output logic                     out_zero,
    output logic                     out_nar,
    output logic [SCALE_W-1:0]       out_scale,
    output logic [BITS-3-ES:0]       out_mant
`ifdef POSIT_FIELD_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [31:0]              stat_count,
    output logic [31:0]              stat_nar
`endif
);

    localparam int FRAC_W = BITS - 3 - ES;

    // Stage 1 registers
    logic               s1_valid;
    logic               s1_sign;
    logic               s1_zero;
    logic               s1_nar;
    logic [ES-1:0]      s1_exp;
    logic [FRAC_W-1:0]  s1_frac;
    logic [SCALE_W-1:0] s1_seed;

    // Stage 2 valid (data lives directly in the output registers)
    logic               s2_valid;

    // Flow control and input-side decode
    logic               s2_adv;
    logic               s1_adv;
    logic               raw_zero;
    logic               raw_nar;
    logic [SCALE_W-1:0] scale_calc;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    assign raw_zero  = (in_raw == '0);
    assign raw_nar   = (in_raw == {1'b1, {(BITS-1){1'b0}}});

    // Two's-complement add at SCALE_W: k shifted into the scale position plus
    // the unsigned exponent field.
    assign scale_calc = (s1_seed << ES) + {{(SCALE_W-ES){1'b0}}, s1_exp};

    // Stage 1: capture decoded fields from the upstream word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
            s1_exp   <= '0;
            s1_frac  <= '0;
            s1_seed  <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            s1_sign  <= in_raw[BITS-1] && !raw_nar;
            s1_zero  <= raw_zero;
            s1_nar   <= raw_nar;
            s1_exp   <= in_shifted[BITS-1 -: ES];
            s1_frac  <= in_shifted[BITS-1-ES -: FRAC_W];
            s1_seed  <= in_seed[SCALE_W-1:0];
        end
    end

    // Stage 2: form scale and mantissa, forcing both to zero for zero/NaR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_sign  <= 1'b0;
            out_zero  <= 1'b0;
            out_nar   <= 1'b0;
            out_scale <= '0;
            out_mant  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            out_sign <= s1_sign;
            out_zero <= s1_zero;
            out_nar  <= s1_nar;
            if (s1_zero || s1_nar) begin
                out_scale <= '0;
                out_mant  <= '0;
            end else begin
                out_scale <= scale_calc;
                out_mant  <= {1'b1, s1_frac};
            end
        end
    end

`ifdef POSIT_FIELD_STATS_EN
    logic out_hs;
    assign out_hs = s2_valid && out_ready;

    // Saturating handshake counters; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_count <= '0;
            stat_nar   <= '0;
        end else if (stat_clr) begin
            stat_count <= '0;
            stat_nar   <= '0;
        end else if (out_hs) begin
            if (stat_count != '1) stat_count <= stat_count + 32'd1;
            if (out_nar && (stat_nar != '1)) stat_nar <= stat_nar + 32'd1;
        end
    end
`endif

endmodule

// File: doc/posit_field_extract.md
Name: posit_field_extract

Overview:
- Registered decode stage directly downstream of seed_lookup in the posit decode path.
- Consumes the regime value (seed) and the regime-stripped word (shifted_data), together with the raw posit.
- Produces sign, zero/NaR flags, the combined signed scale (k*2^ES + e), and the hidden-bit mantissa for the arithmetic core.
- Two-stage pipeline with valid/ready flow control; full throughput when unstalled.

Parameters:
- BITS, 32, posit word width.
- ES, 2, exponent field width.
- SCALE_W, 10, signed scale width. Must hold ±((BITS-1)*2^ES + 2^ES-1).
- Derived: FRAC_W = BITS-3-ES (27 at defaults). Mantissa width is FRAC_W+1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  stage can accept this cycle.
- in_raw  input  BITS  original posit (two's complement form).
- in_seed  input  BITS  signed regime k, computed by seed_lookup on |in_raw|.
- in_shifted  input  BITS  bits following the regime terminator, MSB-aligned at bit BITS-1, zero-filled.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- out_sign  output  1  sign of the value; 0 for zero and NaR.
- out_zero  output  1  in_raw was all zeros.
- out_nar  output  1  in_raw was 1 followed by zeros.
- out_scale  output  SCALE_W  signed k*2^ES + e.
- out_mant  output  FRAC_W+1  {1'b1, fraction}; all zeros when zero or NaR.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0. All outputs 0; in_ready=1 once deasserted.
- Stage 1 capture:
  - Registers zero/NaR detection and sign = in_raw[BITS-1] & !nar.
  - Registers exp = in_shifted[BITS-1 -: ES] and frac = in_shifted[BITS-1-ES -: FRAC_W].
  - Registers in_seed truncated to SCALE_W.
- Stage 2 compute:
  - scale = (seed <<< ES) + exp, signed arithmetic at SCALE_W.
  - mant = {1, frac}.
  - When zero or NaR: scale=0, mant=0.
- Latency: 2 cycles from input handshake to out_valid. One result per cycle sustained.
- Flow control:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no bubble).
  - Stage 2 loads from stage 1 when s2_adv. s2_valid takes s1_valid.
  - Stage 1 loads from inputs when s1_adv. s1_valid takes in_valid.
- Stall: out_valid & !out_ready holds all outputs stable. Stage 1 fills, then in_ready=0. No data is dropped or duplicated.
- Simultaneous events: accept and retire in the same cycle are allowed at both stages when full.
- Data with valid low is don't-care. Registers may load it, but valid bits gate all output meaning.
- ES truncation: when the regime leaves fewer than ES bits, the missing exponent bits read as 0 via the zero-fill of in_shifted. No special casing.
- Reset mid-operation clears both valids immediately; in-flight words are discarded.

Optional Feature:
- Macro: POSIT_FIELD_STATS_EN.
- With the macro defined, two extra outputs are added:
  - stat_count (32 bits): counts each output handshake (out_valid & out_ready).
  - stat_nar (32 bits): counts handshakes with out_nar=1.
  - Both saturate at all-ones and reset to 0.
  - Input stat_clr (1 bit) zeroes both counters synchronously. stat_clr takes priority over an increment in the same cycle.
- Without the macro: these ports and counters do not exist. Datapath behaviour is identical.

Test Plan:
- in_raw=0x40000000, seed=0, shifted=0x00000000, out_ready=1 -> after 2 cycles: sign=0, scale=0, mant=0x8000000.
- in_raw=0x4C000000, seed=0, shifted=0x60000000 -> scale=1, mant=0xC000000 (value 3.0).
- in_raw=0x20000000, seed=-1, shifted=0 -> scale=-4 (0x3FC at SCALE_W=10), mant=0x8000000. Also in_raw=0xC0000000, seed=0, shifted=0 -> sign=1, scale=0.
- in_raw=0x00000000 -> zero=1, sign=0, scale=0, mant=0. in_raw=0x80000000 -> nar=1, sign=0, scale=0, mant=0.
- Back-to-back stream of 8 words with out_ready held low for 3 cycles mid-stream -> in_ready drops after 2 accepted words; outputs stable while stalled; all 8 results exit in order with none lost.
- Assert rst_n low with both stages full -> out_valid=0 and in_ready=1 right after release. With POSIT_FIELD_STATS_EN defined: 5 handshakes including 2 NaR give stat_count=5 and stat_nar=2; stat_clr then returns both to 0.
